// File: rtl/mul_pkg.sv
// Shared definitions for the shift-free multiplication controller:
// state encoding and the datapath/iteration-counter width.
package mul_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CALC   = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage : mul_pkg

// File: rtl/mul_controller.sv
// Control FSM for a repeated-addition multiplier. It sequences operand
// loads into the datapath, repeatedly adds A into P while decrementing B
// until the datapath reports B == 0, then pulses done. The number of add
// iterations is tracked in iter_cnt and held until the next operation.
module mul_controller
  import mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              eqz,
  output logic              ldA,
  output logic              ldB,
  output logic              ldP,
  output logic              clrP,
  output logic              decB,
  output logic              op_sel,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] iter_cnt
);

  state_e              state_q;
  state_e              state_d;
  logic [DATA_W-1:0]   iter_cnt_q;
  logic [DATA_W-1:0]   iter_cnt_d;

  // State and iteration-counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      iter_cnt_q <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      iter_cnt_q <= iter_cnt_d;
    end
  end

  // Next-state, strobe decode and counter update; abort suppresses all
  // strobes and the done pulse in whichever active state it arrives.
  always_comb begin
    state_d    = state_q;
    iter_cnt_d = iter_cnt_q;
    ldA        = 1'b0;
    ldB        = 1'b0;
    ldP        = 1'b0;
    clrP       = 1'b0;
    decB       = 1'b0;
    op_sel     = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = LOAD_A;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_A: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          ldA        = 1'b1;
          op_sel     = 1'b0;
          iter_cnt_d = {DATA_W{1'b0}};
          state_d    = LOAD_B;
        end
      end
      LOAD_B: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          ldB     = 1'b1;
          clrP    = 1'b1;
          op_sel  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!eqz) begin
          ldP        = 1'b1;
          decB       = 1'b1;
          iter_cnt_d = iter_cnt_q + {{(DATA_W-1){1'b0}}, 1'b1};
          state_d    = CALC;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs derived directly from the registered state.
  always_comb begin
    busy     = (state_q != IDLE);
    iter_cnt = iter_cnt_q;
  end

endmodule : mul_controller

// File: tb/tb_mul_controller.sv
// Self-checking bench: mul_controller driving a behavioural
// repeated-addition datapath, with a scoreboard of expected results.
module tb_mul_controller;
  import mul_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              eqz;
  logic              ldA, ldB, ldP, clrP, decB, op_sel, busy, done;
  logic [DATA_W-1:0] iter_cnt;

  // Datapath: operand source, A/B/P registers and zero flag.
  logic [DATA_W-1:0] a_val = 16'd0;
  logic [DATA_W-1:0] b_val = 16'd0;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] dp_a = 16'd0;
  logic [DATA_W-1:0] dp_b = 16'd0;
  logic [31:0]       dp_p = 32'd0;

  typedef struct {
    logic [31:0]       p;
    logic [DATA_W-1:0] iter;
    int                lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  assign data_in = op_sel ? b_val : a_val;
  assign eqz     = (dp_b == 16'd0);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ldA) dp_a <= data_in;
    if (ldB) dp_b <= data_in;
    else if (decB) dp_b <= dp_b - 16'd1;
    if (clrP) dp_p <= 32'd0;
    else if (ldP) dp_p <= dp_p + {16'd0, dp_a};
  end

  mul_controller dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .eqz      (eqz),
    .ldA      (ldA),
    .ldB      (ldB),
    .ldP      (ldP),
    .clrP     (clrP),
    .decB     (decB),
    .op_sel   (op_sel),
    .busy     (busy),
    .done     (done),
    .iter_cnt (iter_cnt)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({ldA, ldB, ldP, clrP, decB, op_sel, busy, done} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {ldA, ldB, ldP, clrP, decB, op_sel, busy, done});
    end
    n_tests++;
    if (iter_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_iter: got %0d want 0", iter_cnt);
    end
    rst = 1'b0;
  endtask

  // One full multiplication; restart_at > 0 re-pulses start in that cycle.
  task automatic test_multiply(input string name, input logic [15:0] a,
                               input logic [15:0] b, input int restart_at);
    exp_t e;
    int   lat = -1;
    int   ldp_n = 0;
    int   decb_n = 0;
    int   done_n = 0;
    int   extra = 0;
    e.p   = 32'(a) * 32'(b);
    e.iter = b;
    e.lat = 4 + int'(b);
    sb.push_back(e);
    @(negedge clk);
    a_val = a;
    b_val = b;
    start = 1'b1;
    abort = 1'b0;
    for (int j = 1; j <= 400; j++) begin
      @(negedge clk);
      start = (j == restart_at) ? 1'b1 : 1'b0;
      if (ldP) ldp_n++;
      if (decB) decb_n++;
      if (done) begin
        done_n++;
        if (lat < 0) lat = j;
      end
      if (lat >= 0 && j > lat) break;
    end
    start = 1'b0;
    e = sb.pop_front();
    n_tests++;
    if (lat !== e.lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, e.lat);
    end
    n_tests++;
    if (dp_p !== e.p) begin
      n_fail++;
      $display("FAIL %s product: got %0d want %0d", name, dp_p, e.p);
    end
    n_tests++;
    if (iter_cnt !== e.iter) begin
      n_fail++;
      $display("FAIL %s iter_cnt: got %0d want %0d", name, iter_cnt, e.iter);
    end
    n_tests++;
    if (ldp_n != int'(b) || decb_n != int'(b)) begin
      n_fail++;
      $display("FAIL %s strobe_count: got ldP=%0d decB=%0d want %0d",
               name, ldp_n, decb_n, b);
    end
    n_tests++;
    if (done_n != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_pulse: got done_n=%0d busy=%b want 1/0",
               name, done_n, busy);
    end
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) extra++;
    end
    n_tests++;
    if (extra != 0 || iter_cnt !== e.iter) begin
      n_fail++;
      $display("FAIL %s idle_hold: got extra=%0d iter=%0d want 0/%0d",
               name, extra, iter_cnt, e.iter);
    end
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || ldA !== 1'b0) begin
      n_fail++;
      $display("FAIL start_abort_idle: got busy=%b ldA=%b want 0/0", busy, ldA);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_abort();
    exp_t e;
    int   late_done = 0;
    e.p = 32'd0; e.iter = 16'd2; e.lat = -1;
    sb.push_back(e);
    @(negedge clk);
    a_val = 16'd6;
    b_val = 16'd10;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({ldA, ldB, ldP, clrP, decB, done} !== 6'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_strobes: got strobes=%b busy=%b want 000000/1",
               {ldA, ldB, ldP, clrP, decB, done}, busy);
    end
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    n_tests++;
    if (busy !== 1'b0 || iter_cnt !== e.iter) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b iter=%0d want 0/%0d",
               busy, iter_cnt, e.iter);
    end
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) late_done++;
    end
    n_tests++;
    if (late_done != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d active cycles want 0", late_done);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a_val = 16'd5;
    b_val = 16'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({ldA, ldB, ldP, clrP, decB, op_sel, busy, done} !== 8'b0 ||
        iter_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got %b iter=%0d want 00000000/0",
               {ldA, ldB, ldP, clrP, decB, op_sel, busy, done}, iter_cnt);
    end
    test_multiply("after_reset", 16'd2, 16'd3, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      test_multiply("b2b", 16'($urandom_range(1, 1000)),
                    16'($urandom_range(0, 8)), -1);
    end
  endtask

  initial begin
    test_reset();
    test_multiply("a7_b5", 16'd7, 16'd5, -1);
    test_multiply("a9_b0", 16'd9, 16'd0, -1);
    test_multiply("restart_in_calc", 16'd3, 16'd4, 4);
    test_start_abort_idle();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mul_controller
